// File: rtl/inst_queue_pkg.sv
// Shared fetch-path types and default sizing for the instruction queue.
package inst_queue_pkg;

  localparam int unsigned DATA_WIDTH    = 32;
  localparam int unsigned ADDR_WIDTH    = 32;
  localparam int unsigned DEF_FETCH_NUM = 4;
  localparam int unsigned DEF_ISSUE_NUM = 4;
  localparam int unsigned DEF_DEPTH     = 32;

  // One queued fetch slot: instruction word, its PC and the predicted-taken bit.
  typedef struct packed {
    logic [DATA_WIDTH-1:0] inst;
    logic [ADDR_WIDTH-1:0] pc;
    logic                  pred;
  } fetch_entry_t;

endpackage

// File: rtl/inst_queue_if.sv
// Fetch-side and decode-side signals of the instruction queue.
interface inst_queue_if #(
  parameter int unsigned FETCH_NUM = inst_queue_pkg::DEF_FETCH_NUM,
  parameter int unsigned ISSUE_NUM = inst_queue_pkg::DEF_ISSUE_NUM,
  parameter int unsigned DEPTH     = inst_queue_pkg::DEF_DEPTH
);
  import inst_queue_pkg::*;

  // Fetch side
  logic [FETCH_NUM-1:0]               in_valid;
  logic [DATA_WIDTH-1:0]              in_inst [FETCH_NUM];
  logic [ADDR_WIDTH-1:0]              in_pc   [FETCH_NUM];
  logic [FETCH_NUM-1:0]               in_pred;
  logic                               in_ready;
  // Decode side
  logic [ISSUE_NUM-1:0]               out_valid;
  logic [DATA_WIDTH-1:0]              out_inst [ISSUE_NUM];
  logic [ADDR_WIDTH-1:0]              out_pc   [ISSUE_NUM];
  logic [ISSUE_NUM-1:0]               out_pred;
  logic [$clog2(ISSUE_NUM+1)-1:0]     deq_num;
  // Status
  logic [$clog2(DEPTH+1)-1:0]         count;
  logic                               empty;
  logic                               full;

  modport master (
    output in_valid, in_inst, in_pc, in_pred, deq_num,
    input  in_ready, out_valid, out_inst, out_pc, out_pred, count, empty, full
  );

  modport slave (
    input  in_valid, in_inst, in_pc, in_pred, deq_num,
    output in_ready, out_valid, out_inst, out_pc, out_pred, count, empty, full
  );

endinterface

// File: rtl/count_ones.sv
// Population count of a bit vector.
module count_ones #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0]             i_bits,
  output logic [$clog2(WIDTH+1)-1:0]   o_count
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  // Sum of set bits
  always_comb begin
    o_count = '0;
    for (int i = 0; i < WIDTH; i++) begin
      o_count = o_count + CNT_W'(i_bits[i]);
    end
  end

endmodule

// File: rtl/inst_queue_lane_compact.sv
// Packs sparse fetch lanes: each valid lane gets its slot offset from the write pointer.
module lane_compact
  import inst_queue_pkg::*;
#(
  parameter int unsigned FETCH_NUM = DEF_FETCH_NUM
) (
  input  logic [FETCH_NUM-1:0]             i_valid,
  output logic [$clog2(FETCH_NUM+1)-1:0]   o_offset [FETCH_NUM],
  output logic [FETCH_NUM-1:0]             o_we
);

  localparam int unsigned OFF_W = $clog2(FETCH_NUM + 1);

  logic [OFF_W-1:0] w_run;

  // Exclusive prefix popcount: lane l lands after all valid lanes below it
  always_comb begin
    w_run = '0;
    for (int l = 0; l < FETCH_NUM; l++) begin
      o_offset[l] = w_run;
      w_run       = w_run + OFF_W'(i_valid[l]);
    end
  end

  assign o_we = i_valid;

endmodule

// File: rtl/inst_queue.sv
// Fetch-to-decode instruction queue: compacting multi-lane enqueue, counted in-order dequeue.
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int unsigned DEPTH     = DEF_DEPTH,
  parameter int unsigned FETCH_NUM = DEF_FETCH_NUM,
  parameter int unsigned ISSUE_NUM = DEF_ISSUE_NUM
) (
  input logic          i_clk,
  input logic          i_rst,
  input logic          i_clr,
  inst_queue_if.slave  bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned NIN_W = $clog2(FETCH_NUM + 1);

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr, r_rptr, w_wptr_next, w_rptr_next;
  logic [CNT_W-1:0] r_count, w_count_next, w_n_out, w_deq_ext;
  logic [NIN_W-1:0] w_n_in;
  logic [NIN_W-1:0] w_offset [FETCH_NUM];
  logic [FETCH_NUM-1:0] w_we;
  logic [PTR_W-1:0] w_rd_idx [ISSUE_NUM];
  logic             w_in_ready, w_enq, w_flush;

  count_ones #(
    .WIDTH (FETCH_NUM)
  ) u_count_ones (
    .i_bits  (bus.in_valid),
    .o_count (w_n_in)
  );

  lane_compact #(
    .FETCH_NUM (FETCH_NUM)
  ) u_lane_compact (
    .i_valid  (bus.in_valid),
    .o_offset (w_offset),
    .o_we     (w_we)
  );

  assign w_flush    = i_rst | i_clr;
  // Ready only from registered count, so no path from deq_num back to fetch.
  assign w_in_ready = (r_count <= CNT_W'(DEPTH - FETCH_NUM));
  assign w_enq      = w_in_ready & (|bus.in_valid);
  assign w_deq_ext  = CNT_W'(bus.deq_num);

  // Clamp dequeue request to occupancy and issue width
  always_comb begin
    w_n_out = w_deq_ext;
    if (w_n_out > r_count)              w_n_out = r_count;
    if (w_n_out > CNT_W'(ISSUE_NUM))    w_n_out = CNT_W'(ISSUE_NUM);
  end

  // Next pointers and occupancy
  always_comb begin
    w_rptr_next  = r_rptr + PTR_W'(w_n_out);
    w_wptr_next  = w_enq ? r_wptr + PTR_W'(w_n_in) : r_wptr;
    w_count_next = r_count + (w_enq ? CNT_W'(w_n_in) : '0) - w_n_out;
  end

  // Pointer/count registers; flush clears them and discards same-cycle traffic
  always_ff @(posedge i_clk) begin
    if (w_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      r_wptr  <= w_wptr_next;
      r_rptr  <= w_rptr_next;
      r_count <= w_count_next;
    end
  end

  // Storage write: valid lanes packed contiguously from the write pointer
  always_ff @(posedge i_clk) begin
    if (w_enq && !w_flush) begin
      for (int l = 0; l < FETCH_NUM; l++) begin
        if (w_we[l]) begin
          r_mem[r_wptr + PTR_W'(w_offset[l])] <= '{inst: bus.in_inst[l],
                                                   pc:   bus.in_pc[l],
                                                   pred: bus.in_pred[l]};
        end
      end
    end
  end

  // Head slots read straight from storage; thermometer valid from count
  always_comb begin
    for (int k = 0; k < ISSUE_NUM; k++) begin
      w_rd_idx[k]      = r_rptr + PTR_W'(k);
      bus.out_valid[k] = (r_count > CNT_W'(k));
      bus.out_inst[k]  = r_mem[w_rd_idx[k]].inst;
      bus.out_pc[k]    = r_mem[w_rd_idx[k]].pc;
      bus.out_pred[k]  = r_mem[w_rd_idx[k]].pred;
    end
  end

  assign bus.in_ready = w_in_ready;
  assign bus.count    = r_count;
  assign bus.empty    = (r_count == '0);
  assign bus.full     = (r_count == CNT_W'(DEPTH));

endmodule

// File: tb/tb_inst_queue.sv
// Directed and reference-model checks for inst_queue.
module tb_inst_queue;

  localparam int unsigned DEPTH = 32;
  localparam int unsigned FN    = 4;
  localparam int unsigned IN    = 4;

  logic clk, rst, clr;
  int   n_assert = 0;
  int   n_fail   = 0;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        pred;
  } ent_t;
  ent_t mq[$];

  inst_queue_if #(.FETCH_NUM(FN), .ISSUE_NUM(IN), .DEPTH(DEPTH)) bus ();

  inst_queue #(
    .DEPTH     (DEPTH),
    .FETCH_NUM (FN),
    .ISSUE_NUM (IN)
  ) u_dut (
    .i_clk (clk),
    .i_rst (rst),
    .i_clr (clr),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid = '0;
    bus.deq_num  = '0;
    clr          = 1'b0;
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    clr = 1'b0;
    idle();
    for (int l = 0; l < FN; l++) begin
      bus.in_inst[l] = 32'hA0 + 32'(l);
      bus.in_pc[l]   = 32'h100 + 32'(4 * l);
    end
    bus.in_pred = 4'b1000;
    step();
    step();
    rst = 1'b0;

    // Reset state
    chk("rst_count", 64'(bus.count), 0);
    chk("rst_empty", 64'(bus.empty), 1);
    chk("rst_full", 64'(bus.full), 0);
    chk("rst_ready", 64'(bus.in_ready), 1);
    chk("rst_ovalid", 64'(bus.out_valid), 0);

    // Compaction of lanes 1 and 3
    bus.in_valid = 4'b1010;
    step();
    idle();
    chk("cmp_count", 64'(bus.count), 2);
    chk("cmp_ovalid", 64'(bus.out_valid), 64'b0011);
    chk("cmp_inst0", 64'(bus.out_inst[0]), 64'hA1);
    chk("cmp_inst1", 64'(bus.out_inst[1]), 64'hA3);
    chk("cmp_pc0", 64'(bus.out_pc[0]), 64'h104);
    chk("cmp_pc1", 64'(bus.out_pc[1]), 64'h10C);
    chk("cmp_pred", 64'(bus.out_pred[1:0]), 64'b10);
    bus.deq_num = 3'd2;
    step();
    idle();
    chk("drain_count", 64'(bus.count), 0);
    chk("drain_empty", 64'(bus.empty), 1);

    // Fill and back-pressure
    bus.in_valid = 4'b1111;
    repeat (7) step();
    chk("fill28_count", 64'(bus.count), 28);
    chk("fill28_ready", 64'(bus.in_ready), 1);
    chk("fill28_full", 64'(bus.full), 0);
    step();
    chk("fill32_count", 64'(bus.count), 32);
    chk("fill32_full", 64'(bus.full), 1);
    chk("fill32_ready", 64'(bus.in_ready), 0);
    step();
    idle();
    chk("ignored_count", 64'(bus.count), 32);
    chk("full_ovalid", 64'(bus.out_valid), 64'b1111);
    chk("full_inst0", 64'(bus.out_inst[0]), 64'hA0);
    chk("full_inst3", 64'(bus.out_inst[3]), 64'hA3);

    // Simultaneous enqueue/dequeue and clamp
    clr = 1'b1;
    step();
    idle();
    chk("clr_count", 64'(bus.count), 0);
    bus.in_valid = 4'b0111;
    step();
    idle();
    chk("sim3_count", 64'(bus.count), 3);
    bus.in_valid = 4'b1111;
    bus.deq_num  = 3'd2;
    step();
    idle();
    chk("sim5_count", 64'(bus.count), 5);
    bus.deq_num = 3'd3;
    step();
    idle();
    chk("deq3_count", 64'(bus.count), 2);
    bus.deq_num = 3'd4;
    step();
    idle();
    chk("clamp_count", 64'(bus.count), 0);
    chk("clamp_empty", 64'(bus.empty), 1);

    // Flush with traffic in the same cycle
    bus.in_valid = 4'b1111;
    repeat (4) step();
    bus.in_valid = 4'b0001;
    step();
    idle();
    chk("pre_flush_count", 64'(bus.count), 17);
    bus.in_valid = 4'b1111;
    bus.deq_num  = 3'd2;
    clr          = 1'b1;
    step();
    idle();
    chk("flush_count", 64'(bus.count), 0);
    chk("flush_ovalid", 64'(bus.out_valid), 0);
    bus.in_inst[0] = 32'hBEEF;
    bus.in_pc[0]   = 32'h2000;
    bus.in_valid   = 4'b0001;
    step();
    idle();
    chk("post_flush_count", 64'(bus.count), 1);
    chk("post_flush_ovalid", 64'(bus.out_valid), 64'b0001);
    chk("post_flush_inst0", 64'(bus.out_inst[0]), 64'hBEEF);
    chk("post_flush_pc0", 64'(bus.out_pc[0]), 64'h2000);

    // Random traffic across pointer wrap against a queue model
    rst = 1'b1;
    step();
    rst = 1'b0;
    mq.delete();
    for (int cyc = 0; cyc < 100; cyc++) begin
      int          nv, n_out, d;
      logic [3:0]  v;
      logic [63:0] exp_ov;
      nv     = (mq.size() > IN) ? IN : mq.size();
      exp_ov = (64'd1 << nv) - 64'd1;
      chk("rnd_count", 64'(bus.count), 64'(mq.size()));
      chk("rnd_ovalid", 64'(bus.out_valid), exp_ov);
      for (int k = 0; k < nv; k++) begin
        chk("rnd_inst", 64'(bus.out_inst[k]), 64'(mq[k].inst));
        chk("rnd_pc", 64'(bus.out_pc[k]), 64'(mq[k].pc));
        chk("rnd_pred", 64'(bus.out_pred[k]), 64'(mq[k].pred));
      end
      v = 4'($urandom_range(0, 15));
      d = int'($urandom_range(0, 4));
      bus.in_valid = v;
      bus.deq_num  = 3'(d);
      for (int l = 0; l < FN; l++) begin
        bus.in_inst[l] = 32'h1000_0000 + 32'(cyc * 4 + l);
        bus.in_pc[l]   = 32'h8000_0000 + 32'((cyc * 4 + l) * 4);
        bus.in_pred[l] = 1'($urandom);
      end
      n_out = d;
      if (n_out > mq.size()) n_out = mq.size();
      if (n_out > IN) n_out = IN;
      for (int k = 0; k < n_out; k++) void'(mq.pop_front());
      if ((mq.size() + n_out) <= (DEPTH - FN) && v != 4'b0) begin
        for (int l = 0; l < FN; l++) begin
          if (v[l]) mq.push_back('{inst: bus.in_inst[l], pc: bus.in_pc[l],
                                   pred: bus.in_pred[l]});
        end
      end
      step();
    end
    idle();
    chk("rnd_final_count", 64'(bus.count), 64'(mq.size()));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
